fft_frame_ctrl: RTL and testbench
=================================

// Module: fft_frame_ctrl
// PURPOSE
//  Frame sequencer wrapped around the fft core. Accepts N real samples over a
//  valid/ready stream and drives the core load/start strobes. Waits for core
//  done, then streams N complex results with a last marker. Clears the core for
//  the next frame. Adds a done-watchdog and a synchronous abort.
// PARAMETERS
//  width    16   real/imag bit width (core data width)
//  N_2      5    log2(points); N = 2**N_2
//  RD_LAT   1    cycles from core done (or address advance) to valid wd data
//  TIMEOUT  256  max cycles in RUN before watchdog fires (must be > N_2*N/2)
// PORTS
//  clk        in   1        clock
//  reset      in   1        asynchronous, active-high reset
//  abort      in   1        synchronous frame abort
//  s_valid    in   1        input sample valid
//  s_ready    out  1        controller can accept a sample
//  s_data     in   width    real input sample
//  m_valid    out  1        output word valid (no backpressure)
//  m_last     out  1        marks word N-1 of a frame
//  m_data     out  2*width  {re,im} result = fft_wd
//  fft_reset  out  1        core reset
//  fft_start  out  1        core start pulse
//  fft_load   out  1        core load strobe
//  fft_rd     out  width    core sample input = s_data
//  fft_wd     in   2*width  core result
//  fft_done   in   1        core done level
//  busy       out  1        state != LOAD or sample count != 0
//  err        out  1        sticky watchdog flag; cleared by reset or abort
//  frame_cnt  out  16       completed frames, wraps at 2**16
// BEHAVIOUR
//  - States: LOAD, START, RUN, DRAIN, CLEAR. Reset state is LOAD.
//  - Reset values: count=0, state=LOAD, all registered outputs 0.
//    fft_reset = reset | (state==CLEAR), so the core is held reset during reset.
//  - LOAD: s_ready=1. fft_load = s_valid & s_ready, for exactly one core load per
//    accepted sample. fft_rd = s_data.
//    scnt increments per accept; the accept at scnt==N-1 wraps scnt to 0 -> START.
//    No accept when s_valid is low; gaps are allowed.
//  - START: fft_start=1 for exactly one cycle; s_ready=0 -> RUN.
//  - RUN: wcnt counts cycles from 0.
//    fft_done=1 -> DRAIN with wcnt cleared.
//    wcnt==TIMEOUT-1 without done -> err<=1 -> CLEAR.
//  - DRAIN: wait RD_LAT cycles, then m_valid=1 for N consecutive cycles.
//    m_data=fft_wd. ocnt counts 0..N-1. m_last=1 when ocnt==N-1.
//    After the last word -> CLEAR and frame_cnt+=1.
//    fft_done dropping in DRAIN -> err<=1 -> CLEAR, frame_cnt unchanged.
//  - CLEAR: fft_reset=1 for one cycle; s_ready=0; counters cleared -> LOAD.
//  - abort (any state except CLEAR) -> CLEAR next cycle. Partial outputs are not
//    completed: m_valid/m_last=0 from the abort cycle on. err<=0.
//    abort in CLEAR is ignored; abort outranks all other transitions.
//  - fft_start, fft_load and m_valid are never high together; s_ready=0 outside LOAD.
//  - Async reset mid-frame returns to LOAD immediately. Partial samples are discarded.
//  - Latency: last accepted sample -> fft_start on the next cycle. Core done ->
//    first m_valid after RD_LAT+1 cycles. Frame period >= N+1+run+1+RD_LAT+N+1.
// TESTING
//  - Continuous s_valid, N=32 impulse (x[0]=16'h0100, rest 0) -> 32 fft_load
//    pulses, one fft_start; 32 m_valid words with equal re=16'h0100 (core scaling);
//    m_last on word 31; frame_cnt=1.
//  - s_valid toggled every other cycle -> exactly 32 fft_load pulses over 64 cycles.
//    Output matches the continuous case.
//  - Core model never asserts done -> err=1 after TIMEOUT cycles in RUN; one-cycle
//    fft_reset; state LOAD; frame_cnt unchanged.
//  - abort at output word 10 -> m_valid low next cycle; no m_last.
//    Next full frame yields 32 words with frame_cnt=1.
//  - Async reset asserted mid-LOAD (scnt=17) -> s_ready=1, scnt=0, fft_reset high
//    while reset is asserted. Next frame is correct.
//  - Two back-to-back frames with RD_LAT=2 -> each frame 32 words;
//    frame_cnt=2; no overlap of fft_load with m_valid.

Source files
------------

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer around an FFT core: loads N real samples, starts the core,
// waits for done, streams N complex results with a last marker, then clears the core.
module fft_frame_ctrl #(
  parameter int width   = 16,
  parameter int N_2     = 5,
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 abort,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [width-1:0]     s_data,
  output logic                 m_valid,
  output logic                 m_last,
  output logic [2*width-1:0]   m_data,
  output logic                 fft_reset,
  output logic                 fft_start,
  output logic                 fft_load,
  output logic [width-1:0]     fft_rd,
  input  logic [2*width-1:0]   fft_wd,
  input  logic                 fft_done,
  output logic                 busy,
  output logic                 err,
  output logic [15:0]          frame_cnt
);

  localparam int                WCNT_W    = $clog2(TIMEOUT);
  localparam logic [N_2-1:0]    LAST_IDX  = '1;
  localparam logic [WCNT_W-1:0] WDOG_LAST = WCNT_W'(TIMEOUT - 1);
  localparam logic [WCNT_W-1:0] LAT_LAST  = WCNT_W'(RD_LAT - 1);

  typedef enum logic [2:0] {LOAD, START, RUN, DRAIN, CLEAR} state_t;

  state_t            state_reg;
  logic [N_2-1:0]    scnt_reg;
  logic [N_2-1:0]    ocnt_reg;
  logic [WCNT_W-1:0] wcnt_reg;
  logic              out_phase_reg;
  logic              err_reg;
  logic [15:0]       frame_cnt_reg;

  // Abort suppresses both acceptance and output in the very cycle it is raised.
  assign s_ready   = (state_reg == LOAD) & ~abort;
  assign fft_load  = s_valid & s_ready;
  assign fft_rd    = s_data;
  assign fft_start = (state_reg == START);
  assign fft_reset = reset | (state_reg == CLEAR);
  assign m_valid   = (state_reg == DRAIN) & out_phase_reg & ~abort;
  assign m_last    = m_valid & (ocnt_reg == LAST_IDX);
  assign m_data    = fft_wd;
  assign busy      = (state_reg != LOAD) | (scnt_reg != '0);
  assign err       = err_reg;
  assign frame_cnt = frame_cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= LOAD;
      scnt_reg      <= '0;
      ocnt_reg      <= '0;
      wcnt_reg      <= '0;
      out_phase_reg <= 1'b0;
      err_reg       <= 1'b0;
      frame_cnt_reg <= '0;
    end else if (abort && state_reg != CLEAR) begin
      state_reg     <= CLEAR;
      out_phase_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      case (state_reg)
        LOAD: begin
          if (fft_load) begin
            scnt_reg <= scnt_reg + 1'b1;
            if (scnt_reg == LAST_IDX) state_reg <= START;
          end
        end
        START: begin
          wcnt_reg  <= '0;
          state_reg <= RUN;
        end
        RUN: begin
          if (fft_done) begin
            wcnt_reg  <= '0;
            state_reg <= DRAIN;
          end else if (wcnt_reg == WDOG_LAST) begin
            err_reg   <= 1'b1;
            state_reg <= CLEAR;
          end else begin
            wcnt_reg <= wcnt_reg + 1'b1;
          end
        end
        DRAIN: begin
          // wcnt is reused to cover the core read latency before words appear.
          if (!fft_done) begin
            err_reg       <= 1'b1;
            out_phase_reg <= 1'b0;
            state_reg     <= CLEAR;
          end else if (!out_phase_reg) begin
            if (wcnt_reg == LAT_LAST) out_phase_reg <= 1'b1;
            else                      wcnt_reg      <= wcnt_reg + 1'b1;
          end else begin
            ocnt_reg <= ocnt_reg + 1'b1;
            if (ocnt_reg == LAST_IDX) begin
              out_phase_reg <= 1'b0;
              frame_cnt_reg <= frame_cnt_reg + 16'd1;
              state_reg     <= CLEAR;
            end
          end
        end
        CLEAR: begin
          scnt_reg      <= '0;
          ocnt_reg      <= '0;
          wcnt_reg      <= '0;
          out_phase_reg <= 1'b0;
          state_reg     <= LOAD;
        end
        default: state_reg <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Scoreboard bench for fft_frame_ctrl with a behavioural tracer core:
// result word k = {x[0], x[k]}, so an impulse gives a flat re of x[0].
module tb_fft_frame_ctrl;
  localparam int W       = 16;
  localparam int N_2     = 5;
  localparam int N       = 32;
  localparam int RD_LAT  = 2;
  localparam int TIMEOUT = 256;
  localparam int RUN_CYC = 12;

  logic           clk = 1'b0;
  logic           reset, abort, s_valid, s_ready;
  logic [W-1:0]   s_data;
  logic           m_valid, m_last;
  logic [2*W-1:0] m_data;
  logic           fft_reset, fft_start, fft_load;
  logic [W-1:0]   fft_rd;
  logic [2*W-1:0] fft_wd;
  logic           fft_done;
  logic           busy, err;
  logic [15:0]    frame_cnt;

  always #5 clk = ~clk;

  fft_frame_ctrl #(.width(W), .N_2(N_2), .RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .abort(abort),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_last(m_last), .m_data(m_data),
    .fft_reset(fft_reset), .fft_start(fft_start), .fft_load(fft_load), .fft_rd(fft_rd),
    .fft_wd(fft_wd), .fft_done(fft_done),
    .busy(busy), .err(err), .frame_cnt(frame_cnt)
  );

  // Core model: stores loaded samples, raises done RUN_CYC cycles after start,
  // then advances its read address so word k is valid RD_LAT+1+k cycles after done.
  logic [W-1:0]   xmem [N];
  int             lcnt, rcnt, ocyc;
  logic           running, done_r, hang;
  logic [N_2-1:0] rd_addr;

  always @(posedge clk) begin
    if (fft_reset) begin
      lcnt <= 0; rcnt <= 0; ocyc <= 0; running <= 1'b0; done_r <= 1'b0;
    end else begin
      if (fft_load) begin
        xmem[lcnt[N_2-1:0]] <= fft_rd;
        lcnt <= lcnt + 1;
      end
      if (fft_start && !hang) begin
        running <= 1'b1; rcnt <= 0;
      end else if (running) begin
        if (rcnt == RUN_CYC - 1) begin
          running <= 1'b0; done_r <= 1'b1; ocyc <= 0;
        end else rcnt <= rcnt + 1;
      end else if (done_r) ocyc <= ocyc + 1;
    end
  end
  assign rd_addr  = N_2'(ocyc - (RD_LAT + 1));
  assign fft_done = done_r;
  assign fft_wd   = done_r ? {xmem[0], xmem[rd_addr]} : '0;

  typedef struct packed { logic [2*W-1:0] data; logic last; } exp_t;
  exp_t q[$];
  int checks = 0, failures = 0;
  int cyc = 0, loads = 0, starts = 0, clears = 0, words = 0;
  int last_start_cyc = 0, last_clear_cyc = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: sample at the falling edge, pop the scoreboard on every output word.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!reset) begin
      if (fft_load) loads++;
      if (fft_start) begin starts++; last_start_cyc = cyc; end
      if (fft_reset) begin clears++; last_clear_cyc = cyc; end
      if (fft_load || fft_start || m_valid)
        chk("exclusive", int'(fft_load) + int'(fft_start) + int'(m_valid), 1);
      if (m_valid) begin
        words++;
        if (q.size() == 0) chk("unexpected_word", words, 0);
        else begin
          e = q.pop_front();
          chk("m_data", m_data, e.data);
          chk("m_last", m_last, e.last);
          $display("word %0d data=%h last=%0d", words, m_data, m_last);
        end
      end
    end
  end

  function automatic logic [W-1:0] sample(input int kind, input int n);
    case (kind)
      0:       return (n == 0) ? 16'h0100 : 16'h0000;
      1:       return 16'h0200 + 16'(3 * n);
      default: return 16'h1000 - 16'(n);
    endcase
  endfunction

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic push_frame(input int kind, input int count);
    exp_t e;
    for (int k = 0; k < count; k++) begin
      e.data = {sample(kind, 0), sample(kind, k)};
      e.last = (k == N - 1);
      q.push_back(e);
    end
  endtask

  // Enter and leave aligned one time unit after a rising edge.
  task automatic send_frame(input int kind, input bit gap, input int count);
    int b;
    for (int n = 0; n < count; n++) begin
      s_valid = 1'b1;
      s_data  = sample(kind, n);
      b = 0;
      do begin @(negedge clk); b++; end while (!s_ready && b < 1000);
      if (b >= 1000) chk("s_ready_timeout", 0, 1);
      @(posedge clk); #1;
      if (gap) begin s_valid = 1'b0; @(posedge clk); #1; end
    end
    s_valid = 1'b0;
    $display("sent frame kind=%0d count=%0d gap=%0d", kind, count, gap);
  endtask

  task automatic wait_idle();
    int b = 0;
    do begin tick(); b++; end while (busy && b < 2000);
    if (b >= 2000) chk("idle_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int l0, s0, c0, t0, w0, b;
    reset = 1'b1; abort = 1'b0; s_valid = 1'b0; s_data = '0; hang = 1'b0;
    tick(); tick();
    chk("rst_fft_reset", fft_reset, 1);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_m_valid", m_valid, 0);
    @(posedge clk); #1; reset = 1'b0;
    tick();
    chk("idle_fft_reset", fft_reset, 0);
    @(posedge clk); #1;

    // Continuous impulse frame
    l0 = loads; s0 = starts;
    push_frame(0, N);
    send_frame(0, 1'b0, N);
    wait_idle();
    chk("cont_loads", loads - l0, N);
    chk("cont_starts", starts - s0, 1);
    chk("cont_frame_cnt", frame_cnt, 1);

    // Same impulse with s_valid toggled every other cycle
    l0 = loads; t0 = cyc;
    push_frame(0, N);
    send_frame(0, 1'b1, N);
    chk("gap_cycles", cyc - t0, 2 * N);
    chk("gap_loads", loads - l0, N);
    wait_idle();
    chk("gap_frame_cnt", frame_cnt, 2);

    // Core never finishes: watchdog
    hang = 1'b1; c0 = clears;
    send_frame(0, 1'b0, N);
    b = 0;
    do begin tick(); b++; end while (!err && b < TIMEOUT + 50);
    chk("wdog_err", err, 1);
    chk("wdog_cycles", last_clear_cyc - last_start_cyc, TIMEOUT + 1);
    wait_idle();
    chk("wdog_clear_len", clears - c0, 1);
    chk("wdog_s_ready", s_ready, 1);
    chk("wdog_frame_cnt", frame_cnt, 2);
    hang = 1'b0;

    // Abort once word 10 has been seen
    push_frame(0, 11);
    w0 = words;
    send_frame(0, 1'b0, N);
    b = 0;
    do begin tick(); b++; end while (words < w0 + 11 && b < 600);
    chk("abort_reach", words - w0, 11);
    @(posedge clk); #1; abort = 1'b1;
    @(negedge clk);
    chk("abort_m_valid", m_valid, 0);
    @(posedge clk); #1; abort = 1'b0;
    chk("abort_err_clr", err, 0);
    wait_idle();
    chk("abort_words", words - w0, 11);
    chk("abort_frame_cnt", frame_cnt, 2);
    push_frame(0, N);
    send_frame(0, 1'b0, N);
    wait_idle();
    chk("post_abort_frame_cnt", frame_cnt, 3);

    // Async reset mid-LOAD after 17 samples
    send_frame(1, 1'b0, 17);
    chk("midload_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("midload_s_ready", s_ready, 1);
    chk("midload_fft_reset", fft_reset, 1);
    chk("midload_busy_clr", busy, 0);
    tick();
    chk("midload_frame_cnt", frame_cnt, 0);
    @(posedge clk); #1; reset = 1'b0;
    push_frame(1, N);
    send_frame(1, 1'b0, N);
    wait_idle();
    chk("post_reset_frame_cnt", frame_cnt, 1);

    // Back-to-back frames
    l0 = loads; s0 = starts;
    push_frame(1, N);
    push_frame(2, N);
    send_frame(1, 1'b0, N);
    send_frame(2, 1'b0, N);
    wait_idle();
    chk("b2b_loads", loads - l0, 2 * N);
    chk("b2b_starts", starts - s0, 2);
    chk("b2b_frame_cnt", frame_cnt, 3);

    repeat (4) tick();
    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
